// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: arbitrates two write-back requesters onto the register file's single write port
module regfile_wb_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int REGFILE_WIDTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        a_valid,
    output logic                        a_ready,
    input  logic [REGFILE_WIDTH-1:0]    a_addr,
    input  logic [DATA_WIDTH-1:0]       a_data,
    input  logic                        b_valid,
    output logic                        b_ready,
    input  logic [REGFILE_WIDTH-1:0]    b_addr,
    input  logic [DATA_WIDTH-1:0]       b_data,
    output logic                        wen,
    output logic [REGFILE_WIDTH-1:0]    wadd,
    output logic [DATA_WIDTH-1:0]       wdat,
    output logic [(1<<REGFILE_WIDTH)-1:0] pending
);
    localparam int NREG = 1 << REGFILE_WIDTH;

    logic                     full_a, full_b;
    logic [REGFILE_WIDTH-1:0] addr_a, addr_b;
    logic [DATA_WIDTH-1:0]    data_a, data_b;
    logic                     a_older, last_a;
    logic                     grant_a, grant_b, load_a, load_b;

    // Same-address pairs go oldest first to keep program order; otherwise alternate.
    assign grant_a = full_a && (!full_b || ((addr_a == addr_b) ? a_older : !last_a));
    assign grant_b = full_b && !grant_a;
    assign a_ready = !rst && (!full_a || grant_a);
    assign b_ready = !rst && (!full_b || grant_b);
    assign load_a  = a_valid && a_ready;
    assign load_b  = b_valid && b_ready;

    // Holding slots: refill has priority over drain so a slot can turn over in one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            full_a <= 1'b0;
            full_b <= 1'b0;
            addr_a <= '0;
            addr_b <= '0;
            data_a <= '0;
            data_b <= '0;
        end else begin
            if (load_a) begin
                full_a <= 1'b1;
                addr_a <= a_addr;
                data_a <= a_data;
            end else if (grant_a) begin
                full_a <= 1'b0;
            end
            if (load_b) begin
                full_b <= 1'b1;
                addr_b <= b_addr;
                data_b <= b_data;
            end else if (grant_b) begin
                full_b <= 1'b0;
            end
        end
    end

    // Age and round-robin history: a newcomer is younger only if the other entry survives the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_older <= 1'b1;
            last_a  <= 1'b0;
        end else begin
            if (grant_a || grant_b)
                last_a <= grant_a;
            if (load_a && load_b)
                a_older <= 1'b1;
            else if (load_a)
                a_older <= !(full_b && !grant_b);
            else if (load_b)
                a_older <= full_a && !grant_a;
        end
    end

    // Registered write port; address and data hold when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wen  <= 1'b0;
            wadd <= '0;
            wdat <= '0;
        end else begin
            wen <= grant_a || grant_b;
            if (grant_a) begin
                wadd <= addr_a;
                wdat <= data_a;
            end else if (grant_b) begin
                wadd <= addr_b;
                wdat <= data_b;
            end
        end
    end

    // Hazard mask over both slots and the output stage, forced clear during reset.
    always_comb begin
        pending = '0;
        for (int r = 0; r < NREG; r++)
            pending[r] = !rst && ((full_a && addr_a == REGFILE_WIDTH'(r)) ||
                                  (full_b && addr_b == REGFILE_WIDTH'(r)) ||
                                  (wen && wadd == REGFILE_WIDTH'(r)));
    end
endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter and sequencer for the register file's single write port (WEN/WADD/WDAT). Two write-back producers share the port through valid/ready handshakes: requester A is ALU results and requester B is load and multi-cycle results. Each requester has a one-entry holding slot. Writes are issued in age order with round-robin fairness. A pending-write bitmask is exported for hazard detection in decode.

## Interface
- DATA_WIDTH, 32, write data width; matches the register file.
- REGFILE_WIDTH, 4, register address width; 2^REGFILE_WIDTH registers.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- a_valid  in  1  requester A presents a write.
- a_ready  out  1  A's slot can accept this cycle.
- a_addr  in  REGFILE_WIDTH  A's destination register.
- a_data  in  DATA_WIDTH  A's write data.
- b_valid, b_ready, b_addr, b_data  same as the A signals, for requester B.
- wen  out  1  write enable to the register file (registered).
- wadd  out  REGFILE_WIDTH  write address (registered).
- wdat  out  DATA_WIDTH  write data (registered).
- pending  out  2^REGFILE_WIDTH  bit r set while any slot or the output stage holds a write to register r.

## Operation
- **Slots.** Per-requester state is `full_x`, `addr_x` and `data_x`.
  - `x_ready = !rst && (!full_x || grant_x)`: a slot can refill in the same cycle it drains.
  - A transfer occurs when `x_valid && x_ready`; the slot loads at the clock edge.
- **Age tracking.** An `a_older` bit records which full slot was accepted first.
  - It is set when A loads while B is not full, or while B is being granted.
  - It is cleared in the symmetric case for B.
  - If A and B load in the same cycle into empty slots, A is older.
- **Arbitration** (combinational, among full slots):
  - Only one slot full → grant it.
  - Both full, same address → grant the older slot. This preserves program order, so the last accepted write wins.
  - Both full, different addresses → round-robin. `last` is the requester granted most recently; grant the other one. `last` resets to B, so A wins the first tie.
- **Output stage.** At each edge, `wen <= |grant`, and `wadd`/`wdat` load from the granted slot. When there is no grant, `wen` = 0 and `wadd`/`wdat` hold their previous values. One write per cycle maximum.
- **Pending mask.** `pending` = decode(addr_a)&full_a | decode(addr_b)&full_b | decode(wadd)&wen. It is combinational from registered state. A bit clears on the cycle after the register file's write edge.
- **Arithmetic.** No address wrap arithmetic is needed; addresses are used exactly as given, with full REGFILE_WIDTH decode.
- **Reset.** While `rst` = 1:
  - slots are emptied and in-flight data is discarded; no partial write is issued;
  - `wen` = 0, `wadd` = 0, `wdat` = 0, `pending` = 0, `a_ready` = `b_ready` = 0, `last` = B, `a_older` = 1.
  - Holding `wen` low during reset guarantees the register file's reset initialisation is not overwritten.

## Timing
- **Latency.** Accept at edge N → slot full after N → granted in cycle N+1 → `wen` high after edge N+1 → register file updated at edge N+2. With no contention, a new write can be accepted every cycle per requester.
- **Throughput.** Aggregate throughput is one write per cycle. Under continuous contention, A and B alternate, and each sees `ready` = 1 on alternate cycles.
- **Back-to-back.** A slot granted in cycle C accepts new data in cycle C. The new data is eligible for grant at C+1.
- **Simultaneous events.** Accept and grant on the same slot in one cycle is legal. The new entry replaces the old at the edge; `full` stays 1 and `pending` reflects the new address the next cycle.
- **Ready/valid protocol.** `x_ready` does not depend on `x_valid`. Requesters must hold `addr`/`data` stable while `valid` is high and `ready` is low.
- **Reset mid-operation.** A reset asserted while `wen` = 1 forces `wen` = 0 from the next edge onward. Any write already registered completes at that edge only if `rst` was 0 when it was captured.

## Test plan
- **Reset.** Assert `rst` 2 cycles with `a_valid` = `b_valid` = 1 → `wen` = 0, `pending` = 0, both ready = 0. Release → both ready = 1, no write issued for stale data.
- **Single write.** A writes r3 = 0xDEADBEEF at edge N → `wen` = 1, `wadd` = 3, `wdat` = 0xDEADBEEF in cycle N+1 to N+2. `pending[3]` = 1 for exactly 2 cycles, then 0.
- **Contention, different addresses.** A and B both valid every cycle, A→r1, B→r2, for 6 cycles → `wen` continuously 1, `wadd` sequence 1,2,1,2,1,2 (A first after reset). Each requester's `ready` toggles 1,0,1,0.
- **Same-address ordering.** B accepts r5 = 0x11 at edge N; A accepts r5 = 0x22 at edge N+1 while B is still full → writes issue B (0x11) then A (0x22). Final r5 = 0x22. Same-cycle acceptance gives A first, B last.
- **Refill on drain.** A streams r0..r7 with `b_valid` = 0 → one write per cycle, `a_ready` stays 1, `wadd` = 0..7 in consecutive cycles. `pending` shows at most 2 bits set at any time.
- **Reset mid-stream.** `rst` pulse for 1 cycle during the contention test → `wen` = 0 the following cycle, `pending` = 0, and the post-reset first grant goes to A.
